// File: rtl/nx_mesh_egress.sv
// ============================================================================
// nx_mesh_egress : egress FIFO from a mesh edge node to the host, with
//                  occupancy/accept counters and a host-stall detector.
// Revision 1.0
// ============================================================================
`default_nettype none

module nx_mesh_egress #(
  parameter int STREAM_WIDTH = 32,
  parameter int DEPTH        = 4,
  parameter int STALL_LIMIT  = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  output logic                      present_o,
  input  logic [STREAM_WIDTH-1:0]   ib_data_i,
  input  logic                      ib_valid_i,
  output logic                      ib_ready_o,
  output logic [STREAM_WIDTH-1:0]   host_data_o,
  output logic                      host_valid_o,
  input  logic                      host_ready_i,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [31:0]               count_o,
  output logic                      stall_o,
  output logic                      idle_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_CNT = SW'(STALL_LIMIT);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } state_t;

  logic [STREAM_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q,      wptr_d;
  logic [AW-1:0] rptr_q,      rptr_d;
  logic [LW-1:0] level_q,     level_d;
  logic [31:0]   count_q,     count_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  state_t        state_q,     state_d;
  logic          present_q;

  logic push;
  logic pop;

  // present_q doubles as an "out of reset" qualifier so ready stays low in reset.
  assign ib_ready_o   = present_q && (level_q != FULL_LVL) && !flush_i;
  assign host_valid_o = (level_q != '0);
  assign host_data_o  = mem_q[rptr_q];

  assign push = ib_valid_i && ib_ready_o;
  assign pop  = host_valid_o && host_ready_i && !flush_i;

  assign present_o = present_q;
  assign level_o   = level_q;
  assign count_o   = count_q;
  assign stall_o   = (state_q == ST_STALLED);
  assign idle_o    = (level_q == '0) && !ib_valid_i;

  // Storage carries no reset: contents are meaningless once level is zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= ib_data_i;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        wptr_d  = wptr_q + AW'(1);
        count_d = count_q + 32'd1;
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i || pop || !host_valid_o) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != LIMIT_CNT) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end

    // Entering STALLED on the same edge the counter hits the limit means
    // stall_o rises after exactly STALL_LIMIT stalled cycles.
    case (state_q)
      ST_RUN: begin
        if (!flush_i && (stall_cnt_d == LIMIT_CNT)) begin
          state_d = ST_STALLED;
        end
      end
      ST_STALLED: begin
        if (flush_i || pop) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      state_q     <= ST_RUN;
      present_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      state_q     <= state_d;
      present_q   <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nx_mesh_egress.sv
// Directed self-checking bench for nx_mesh_egress (DEPTH = 4, STALL_LIMIT = 4).
`default_nettype none

module tb_nx_mesh_egress;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          present;
  logic [W-1:0]  ib_data;
  logic          ib_valid;
  logic          ib_ready;
  logic [W-1:0]  host_data;
  logic          host_valid;
  logic          host_ready;
  logic [2:0]    level;
  logic [31:0]   count;
  logic          stall;
  logic          idle;

  int checks = 0;
  int errors = 0;

  nx_mesh_egress #(
    .STREAM_WIDTH (W),
    .DEPTH        (4),
    .STALL_LIMIT  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .flush_i      (flush),
    .present_o    (present),
    .ib_data_i    (ib_data),
    .ib_valid_i   (ib_valid),
    .ib_ready_o   (ib_ready),
    .host_data_o  (host_data),
    .host_valid_o (host_valid),
    .host_ready_i (host_ready),
    .level_o      (level),
    .count_o      (count),
    .stall_o      (stall),
    .idle_o       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ib_valid = 1'b0; ib_data = '0; host_ready = 1'b0;
    #3;
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL rst_ib_ready: got %b expected 0", ib_ready); end
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL rst_host_valid: got %b expected 0", host_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
    checks++; if (present !== 1'b0) begin errors++; $display("FAIL rst_present: got %b expected 0", present); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
    ib_valid = 1'b1;
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b expected 0", idle); end
    ib_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (present !== 1'b1) begin errors++; $display("FAIL rel_present: got %b expected 1", present); end
    checks++; if (ib_ready !== 1'b1) begin errors++; $display("FAIL rel_ib_ready: got %b expected 1", ib_ready); end
  endtask

  task automatic test_single();
    ib_data = 32'hDEADBEEF; ib_valid = 1'b1; host_ready = 1'b1;
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL single_no_passthru: got %b expected 0", host_valid); end
    tick();
    ib_valid = 1'b0;
    checks++; if (host_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", host_valid); end
    checks++; if (host_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", host_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1: got %0d expected 1", level); end
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level0: got %0d expected 0", level); end
    checks++; if (count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
  endtask

  task automatic test_fill();
    host_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ib_data = W'(i); ib_valid = 1'b1;
      tick();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level); end
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", ib_ready); end
    checks++; if (count !== 32'd5) begin errors++; $display("FAIL fill_count: got %0d expected 5", count); end
    host_ready = 1'b1;
    // Full + pop pending: ready must still be low.
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_pop: got %b expected 0", ib_ready); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (host_valid !== 1'b1 || host_data !== W'(k + 1)) begin errors++; $display("FAIL fill_order[%0d]: got v=%b d=%h expected v=1 d=%h", k, host_valid, host_data, k + 1); end
      tick();
      if (k == 1) ib_valid = 1'b0;
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_drain_level: got %0d expected 0", level); end
    checks++; if (count !== 32'd6) begin errors++; $display("FAIL fill_drain_count: got %0d expected 6", count); end
  endtask

  task automatic test_back_to_back();
    host_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ib_data = 32'h100 + W'(i); ib_valid = 1'b1;
      tick();
    end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_prefill: got %0d expected 2", level); end
    host_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ib_data = 32'h102 + W'(i);
      checks++; if (host_data !== 32'h100 + W'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, host_data, 32'h100 + i); end
      tick();
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level[%0d]: got %0d expected 2", i, level); end
    end
    ib_valid = 1'b0;
    checks++; if (count !== 32'd18) begin errors++; $display("FAIL b2b_count: got %0d expected 18", count); end
    checks++; if (host_data !== 32'h10A) begin errors++; $display("FAIL b2b_tail0: got %h expected 10a", host_data); end
    tick();
    checks++; if (host_data !== 32'h10B) begin errors++; $display("FAIL b2b_tail1: got %h expected 10b", host_data); end
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", level); end
  endtask

  task automatic test_flush();
    host_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ib_data = 32'h200 + W'(i); ib_valid = 1'b1;
      tick();
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_prefill: got %0d expected 3", level); end
    flush = 1'b1; ib_data = 32'h203; ib_valid = 1'b1; host_ready = 1'b1;
    #1;
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", ib_ready); end
    tick();
    flush = 1'b0; ib_valid = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", host_valid); end
    checks++; if (count !== 32'd21) begin errors++; $display("FAIL flush_count: got %0d expected 21", count); end
    ib_data = 32'h300; ib_valid = 1'b1; host_ready = 1'b0;
    tick();
    ib_valid = 1'b0;
    checks++; if (host_data !== 32'h300 || level !== 3'd1) begin errors++; $display("FAIL flush_after: got d=%h l=%0d expected d=300 l=1", host_data, level); end
    host_ready = 1'b1;
    tick();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_after_pop: got %0d expected 0", level); end
  endtask

  task automatic test_stall();
    host_ready = 1'b0; ib_data = 32'h400; ib_valid = 1'b1;
    tick();
    ib_valid = 1'b0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_pre: got %b expected 0", stall); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early[%0d]: got %b expected 0", i, stall); end
    end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hit: got %b expected 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b expected 1", stall); end
    host_ready = 1'b1;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected 0", stall); end
    checks++; if (level !== 3'd0 || count !== 32'd23) begin errors++; $display("FAIL stall_post: got l=%0d c=%0d expected l=0 c=23", level, count); end
  endtask

  task automatic test_reset_mid();
    host_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ib_data = 32'h500 + W'(i); ib_valid = 1'b1;
      tick();
    end
    ib_valid = 1'b0;
    checks++; if (level !== 3'd2 || count !== 32'd25) begin errors++; $display("FAIL rmid_pre: got l=%0d c=%0d expected l=2 c=25", level, count); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", level); end
    checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", host_valid); end
    checks++; if (ib_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b expected 0", ib_ready); end
    checks++; if (count !== 32'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (present !== 1'b0 || stall !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL rmid_misc: got p=%b s=%b i=%b expected p=0 s=0 i=1", present, stall, idle); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (level !== 3'd0 || host_valid !== 1'b0 || count !== 32'd0) begin errors++; $display("FAIL rmid_after: got l=%0d v=%b c=%0d expected 0/0/0", level, host_valid, count); end
    checks++; if (ib_ready !== 1'b1 || present !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got r=%b p=%b expected 1/1", ib_ready, present); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
